edge_event_arbiter: RTL

//  Watches N_CH single-bit inputs. Each channel runs its own edge/pulse detector
//  (rise, fall or one-cycle 010 pulse, chosen per channel at run time).

---
 rtl/edge_event_pkg.sv | 26 ++
 rtl/edge_event_channel.sv | 50 +++++
 rtl/edge_event_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/edge_event_pkg.sv
// Shared types for the edge event arbiter: per-channel detector modes and
// the detector function used by every channel.
package edge_event_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_RISE  = 2'd1,
    MODE_FALL  = 2'd2,
    MODE_PULSE = 2'd3
  } mode_t;

  // a_rr/a_r/a are the two previous samples and the current input.
  function automatic logic detect(input mode_t m, input logic a, input logic a_r,
                                  input logic a_rr);
    logic hit;
    hit = 1'b0;
    case (m)
      MODE_RISE:  hit = ~a_r & a;
      MODE_FALL:  hit = a_r & ~a;
      MODE_PULSE: hit = ~a_rr & a_r & ~a;
      default:    hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/edge_event_channel.sv
// One monitored input: history, edge/pulse detection, one-deep pending slot
// with timestamp capture and a sticky lost-event flag.
module edge_event_channel
  import edge_event_pkg::*;
#(
  parameter int TS_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a,
  input  mode_t           mode,
  input  logic            enable,
  input  logic [TS_W-1:0] ts_cnt,
  input  logic            sel,
  input  logic            overflow_clr,
  output logic            pend,
  output logic [TS_W-1:0] ts,
  output logic            overflow
);

  logic a_r;
  logic a_rr;
  logic ev;
  logic keep;
  logic lost;

  assign ev   = enable & detect(mode, a, a_r, a_rr);
  assign keep = pend & ~sel;
  // A slot being handed out this cycle is free again, so only a still-held slot loses events.
  assign lost = ev & keep;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r      <= 1'b0;
      a_rr     <= 1'b0;
      pend     <= 1'b0;
      ts       <= '0;
      overflow <= 1'b0;
    end else begin
      a_r      <= a;
      a_rr     <= a_r;
      pend     <= keep | ev;
      if (ev && !keep) begin
        ts <= ts_cnt;
      end
      overflow <= (overflow & ~overflow_clr) | lost;
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Timestamped edge-event collector: per-channel detectors feed a round-robin
// arbiter that offers one event at a time over a valid/ready output.
module edge_event_arbiter
  import edge_event_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int TS_W = 16,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   a,
  input  logic [2*N_CH-1:0] mode,
  input  logic [N_CH-1:0]   enable,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [TS_W-1:0]   out_ts,
  output logic [N_CH-1:0]   overflow,
  input  logic [N_CH-1:0]   overflow_clr
);

  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts_arr [N_CH];
  logic [N_CH-1:0] pend;
  logic [N_CH-1:0] sel;
  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] grant;
  logic [CH_W-1:0] idx;
  logic            grant_found;
  logic            load;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_event_channel #(
      .TS_W(TS_W)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .a            (a[i]),
      .mode         (mode_t'(mode[2*i +: 2])),
      .enable       (enable[i]),
      .ts_cnt       (ts_cnt),
      .sel          (sel[i]),
      .overflow_clr (overflow_clr[i]),
      .pend         (pend[i]),
      .ts           (ts_arr[i]),
      .overflow     (overflow[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
    end
  end

  // Search starts just after the last granted channel and wraps around.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    idx         = rr_ptr;
    for (int k = 0; k < N_CH; k++) begin
      idx = (idx == CH_W'(N_CH - 1)) ? '0 : idx + 1'b1;
      if (!grant_found && pend[idx]) begin
        grant       = idx;
        grant_found = 1'b1;
      end
    end
  end

  assign load = ~out_valid | out_ready;

  always_comb begin
    sel = '0;
    if (load && grant_found) begin
      sel[grant] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_ts    <= '0;
      rr_ptr    <= CH_W'(N_CH - 1);
    end else if (load) begin
      if (grant_found) begin
        out_valid <= 1'b1;
        out_ch    <= grant;
        out_ts    <= ts_arr[grant];
        rr_ptr    <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
